// File: rtl/cheriot_dv_pkg.sv
// Shared DV-side types for the testbench data-bus arbiter.
//   arb_host_id_t : identifies which host issued an outstanding transaction
//   ArbNumHosts   : number of hosts sharing the data memory port
//   arb_rr_pick   : round-robin choice among requesting hosts
package cheriot_dv_pkg;

    typedef logic arb_host_id_t;

    localparam int unsigned ArbNumHosts = 2;

    // With a single requester that host wins; on a tie the host that was not last granted wins.
    function automatic arb_host_id_t arb_rr_pick(input logic [ArbNumHosts-1:0] req,
                                                 input arb_host_id_t           last);
        arb_host_id_t pick;
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last;
            default: pick = 1'b0;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/tb_arb_id_fifo.sv
// Synchronous FIFO of host IDs recording the issue order of granted transactions.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-high reset (flushes the FIFO)
//   i_push         : push i_push_id (ignored when full)
//   i_pop          : pop the head (ignored when empty)
//   o_head         : host ID at the head
//   o_count        : occupancy, 0..Depth
//   o_full/o_empty : occupancy flags
module tb_arb_id_fifo
    import cheriot_dv_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_push_id,
    output logic                   o_head,
    output logic [$clog2(Depth):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    arb_host_id_t    r_mem [Depth];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == CntW'(Depth));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

    // Pointers wrap naturally since Depth is a power of two.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PtrW'(1);
            if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= i_push_id;
    end

endmodule

// File: rtl/tb_data_bus_arb.sv
// Two-host arbiter sharing one req/gnt/rvalid data memory port.
// Host 0 is the core LSU, host 1 a background traffic master.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-high reset
//   h_*_i / h_*_o          : per-host request side and in-order responses
//   h_rdata_o              : response data shared by both hosts, qualified by h_rvalid_o
//   dev_*_o / dev_*_i      : device (memory model) side
//   outstanding_o          : number of granted transactions awaiting rvalid
//   proto_err_o            : sticky flag for spurious rvalid or a locked host dropping req
module tb_data_bus_arb
    import cheriot_dv_pkg::*;
#(
    parameter int unsigned DataW          = 33,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [ArbNumHosts-1:0]              h_req_i,
    input  logic [ArbNumHosts-1:0]              h_we_i,
    input  logic [ArbNumHosts-1:0]              h_is_cap_i,
    input  logic [ArbNumHosts-1:0][3:0]         h_be_i,
    input  logic [ArbNumHosts-1:0][31:0]        h_addr_i,
    input  logic [ArbNumHosts-1:0][DataW-1:0]   h_wdata_i,
    output logic [ArbNumHosts-1:0]              h_gnt_o,
    output logic [ArbNumHosts-1:0]              h_rvalid_o,
    output logic [ArbNumHosts-1:0]              h_err_o,
    output logic [DataW-1:0]                    h_rdata_o,
    output logic                                dev_req_o,
    output logic                                dev_we_o,
    output logic                                dev_is_cap_o,
    output logic [3:0]                          dev_be_o,
    output logic [31:0]                         dev_addr_o,
    output logic [DataW-1:0]                    dev_wdata_o,
    input  logic                                dev_gnt_i,
    input  logic                                dev_rvalid_i,
    input  logic                                dev_err_i,
    input  logic [DataW-1:0]                    dev_rdata_i,
    output logic [$clog2(MaxOutstanding):0]     outstanding_o,
    output logic                                proto_err_o
);

    logic         r_lock;
    arb_host_id_t r_sel;
    arb_host_id_t r_last;
    logic         r_proto_err;

    logic         w_lock_d;
    arb_host_id_t w_sel_d;
    arb_host_id_t w_last_d;
    logic         w_proto_err_d;

    arb_host_id_t w_sel;
    arb_host_id_t w_head;
    logic         w_full;
    logic         w_empty;
    logic         w_lock_drop;
    logic         w_dev_req;
    logic         w_grant;
    logic         w_pop;
    logic         w_spurious;

    // A locked host keeps the port only while it still requests; a drop falls back to fresh arbitration.
    assign w_lock_drop = r_lock & ~h_req_i[r_sel];
    assign w_sel       = (r_lock && h_req_i[r_sel]) ? r_sel : arb_rr_pick(h_req_i, r_last);
    assign w_dev_req   = (|h_req_i) & ~w_full & ~rst_ni;
    assign w_grant     = w_dev_req & dev_gnt_i;
    assign w_pop       = dev_rvalid_i & ~w_empty & ~rst_ni;
    assign w_spurious  = dev_rvalid_i & w_empty;

    tb_arb_id_fifo #(
        .Depth     (MaxOutstanding)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_push    (w_grant),
        .i_pop     (w_pop),
        .i_push_id (w_sel),
        .o_head    (w_head),
        .o_count   (outstanding_o),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Arbitration state register.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            r_lock      <= 1'b0;
            r_sel       <= 1'b0;
            r_last      <= 1'b1;
            r_proto_err <= 1'b0;
        end else begin
            r_lock      <= w_lock_d;
            r_sel       <= w_sel_d;
            r_last      <= w_last_d;
            r_proto_err <= w_proto_err_d;
        end
    end

    // Next-state: lock an ungranted forwarded request, release on grant or when nothing is forwarded.
    always_comb begin
        w_lock_d      = r_lock;
        w_sel_d       = r_sel;
        w_last_d      = r_last;
        w_proto_err_d = r_proto_err;
        if (w_grant) begin
            w_lock_d = 1'b0;
            w_last_d = w_sel;
        end else if (w_dev_req) begin
            w_lock_d = 1'b1;
            w_sel_d  = w_sel;
        end else begin
            w_lock_d = 1'b0;
        end
        if (w_spurious || w_lock_drop) w_proto_err_d = 1'b1;
    end

    // Combinational request/response paths, all held at zero during reset.
    always_comb begin
        dev_req_o    = 1'b0;
        dev_we_o     = 1'b0;
        dev_is_cap_o = 1'b0;
        dev_be_o     = '0;
        dev_addr_o   = '0;
        dev_wdata_o  = '0;
        h_gnt_o      = '0;
        h_rvalid_o   = '0;
        h_err_o      = '0;
        h_rdata_o    = '0;
        if (!rst_ni) begin
            dev_req_o          = w_dev_req;
            dev_we_o           = h_we_i[w_sel];
            dev_is_cap_o       = h_is_cap_i[w_sel];
            dev_be_o           = h_be_i[w_sel];
            dev_addr_o         = h_addr_i[w_sel];
            dev_wdata_o        = h_wdata_i[w_sel];
            h_gnt_o[w_sel]     = w_grant;
            h_rvalid_o[w_head] = w_pop;
            h_err_o[w_head]    = w_pop & dev_err_i;
            h_rdata_o          = dev_rdata_i;
        end
    end

    assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_tb_data_bus_arb.sv
// Self-checking bench for tb_data_bus_arb: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model (queue of issuing hosts).
module tb_tb_data_bus_arb;

    localparam int unsigned DataW  = 33;
    localparam int unsigned MaxOut = 4;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [1:0]            h_req_i;
    logic [1:0]            h_we_i;
    logic [1:0]            h_is_cap_i;
    logic [1:0][3:0]       h_be_i;
    logic [1:0][31:0]      h_addr_i;
    logic [1:0][DataW-1:0] h_wdata_i;
    logic [1:0]            h_gnt_o;
    logic [1:0]            h_rvalid_o;
    logic [1:0]            h_err_o;
    logic [DataW-1:0]      h_rdata_o;
    logic                  dev_req_o;
    logic                  dev_we_o;
    logic                  dev_is_cap_o;
    logic [3:0]            dev_be_o;
    logic [31:0]           dev_addr_o;
    logic [DataW-1:0]      dev_wdata_o;
    logic                  dev_gnt_i;
    logic                  dev_rvalid_i;
    logic                  dev_err_i;
    logic [DataW-1:0]      dev_rdata_i;
    logic [2:0]            outstanding_o;
    logic                  proto_err_o;

    tb_data_bus_arb #(
        .DataW          (DataW),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .h_req_i       (h_req_i),
        .h_we_i        (h_we_i),
        .h_is_cap_i    (h_is_cap_i),
        .h_be_i        (h_be_i),
        .h_addr_i      (h_addr_i),
        .h_wdata_i     (h_wdata_i),
        .h_gnt_o       (h_gnt_o),
        .h_rvalid_o    (h_rvalid_o),
        .h_err_o       (h_err_o),
        .h_rdata_o     (h_rdata_o),
        .dev_req_o     (dev_req_o),
        .dev_we_o      (dev_we_o),
        .dev_is_cap_o  (dev_is_cap_o),
        .dev_be_o      (dev_be_o),
        .dev_addr_o    (dev_addr_o),
        .dev_wdata_o   (dev_wdata_o),
        .dev_gnt_i     (dev_gnt_i),
        .dev_rvalid_i  (dev_rvalid_i),
        .dev_err_i     (dev_err_i),
        .dev_rdata_i   (dev_rdata_i),
        .outstanding_o (outstanding_o),
        .proto_err_o   (proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Host-side transaction attributes (refreshed after each grant).
    logic [31:0]      haddr  [2];
    logic [DataW-1:0] hwdata [2];
    logic [3:0]       hbe    [2];
    logic             hwe    [2];
    logic             hcap   [2];
    bit               rand_attr = 1'b0;

    // Reference model: issue-order queue plus the arbitration commitments.
    bit mq[$];
    bit m_last;
    bit m_pend;
    bit m_pend_h;
    bit m_proto;

    // Observed DUT activity, used by the directed scenarios.
    bit         dut_glog[$];
    bit         dut_rlog[$];
    int         dut_gcnt[2];
    int         dut_rcnt[2];
    logic [1:0] dut_err_last;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic refresh_host(input int h);
        haddr[h]  = $urandom;
        hwdata[h] = {1'($urandom), 32'($urandom)};
        hbe[h]    = 4'($urandom);
        if (rand_attr) begin
            hwe[h]  = 1'($urandom);
            hcap[h] = 1'($urandom);
        end
    endtask

    // One clock: drive at the falling edge, check 1 time unit later, advance the model.
    task automatic cycle(input logic [1:0] req, input logic gnt, input logic rv, input logic err);
        logic [1:0] eg;
        logic [1:0] erv;
        logic [1:0] eerr;
        bit         esel;
        bit         edreq;
        bit         was_empty;
        bit         drop;
        h_req_i = req;
        for (int h = 0; h < 2; h++) begin
            h_addr_i[h]   = haddr[h];
            h_wdata_i[h]  = hwdata[h];
            h_be_i[h]     = hbe[h];
            h_we_i[h]     = hwe[h];
            h_is_cap_i[h] = hcap[h];
        end
        dev_gnt_i    = gnt;
        dev_rvalid_i = rv;
        dev_err_i    = err;
        dev_rdata_i  = {1'($urandom), 32'($urandom)};
        #1;
        was_empty = (mq.size() == 0);
        drop      = m_pend && !req[m_pend_h];
        if (m_pend && req[m_pend_h]) esel = m_pend_h;
        else if (req == 2'b11)       esel = !m_last;
        else                         esel = req[1];
        edreq = (req != 2'b00) && (mq.size() < MaxOut);
        eg   = 2'b00;
        erv  = 2'b00;
        eerr = 2'b00;
        if (edreq && gnt) eg[esel] = 1'b1;
        if (rv && !was_empty) begin
            erv[mq[0]]  = 1'b1;
            eerr[mq[0]] = err;
        end
        check_val("dev_req", 64'(dev_req_o), 64'(edreq));
        check_val("h_gnt", 64'(h_gnt_o), 64'(eg));
        check_val("h_rvalid", 64'(h_rvalid_o), 64'(erv));
        check_val("h_err", 64'(h_err_o), 64'(eerr));
        check_val("outstanding", 64'(outstanding_o), 64'(mq.size()));
        check_val("proto_err", 64'(proto_err_o), 64'(m_proto));
        if (edreq) begin
            check_val("dev_addr", 64'(dev_addr_o), 64'(haddr[esel]));
            check_val("dev_ctrl", 64'({dev_we_o, dev_is_cap_o, dev_be_o}),
                      64'({hwe[esel], hcap[esel], hbe[esel]}));
            check_val("dev_wdata", 64'(dev_wdata_o), 64'(hwdata[esel]));
        end
        if (erv != 2'b00) check_val("h_rdata", 64'(h_rdata_o), 64'(dev_rdata_i));
        for (int h = 0; h < 2; h++) begin
            if (h_gnt_o[h])    begin dut_glog.push_back(1'(h)); dut_gcnt[h]++; end
            if (h_rvalid_o[h]) begin dut_rlog.push_back(1'(h)); dut_rcnt[h]++; end
        end
        dut_err_last = h_err_o;
        if (!was_empty && rv) void'(mq.pop_front());
        if (eg != 2'b00) begin
            mq.push_back(esel);
            m_last = esel;
            m_pend = 1'b0;
            refresh_host(int'(esel));
        end else if (edreq) begin
            m_pend   = 1'b1;
            m_pend_h = esel;
        end else begin
            m_pend = 1'b0;
        end
        if ((rv && was_empty) || drop) m_proto = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic clear_logs();
        dut_glog.delete();
        dut_rlog.delete();
        dut_gcnt = '{0, 0};
        dut_rcnt = '{0, 0};
    endtask

    // Reset with traffic pending on every input: all outputs must stay at zero.
    task automatic do_reset();
        rst_ni       = 1'b1;
        h_req_i      = 2'b11;
        dev_gnt_i    = 1'b1;
        dev_rvalid_i = 1'b1;
        #1;
        check_val("rst_dev_req", 64'(dev_req_o), 64'd0);
        check_val("rst_h_outs", 64'({h_gnt_o, h_rvalid_o, h_err_o}), 64'd0);
        check_val("rst_dev_addr", 64'(dev_addr_o), 64'd0);
        check_val("rst_state", 64'({outstanding_o, proto_err_o}), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        h_req_i      = 2'b00;
        dev_gnt_i    = 1'b0;
        dev_rvalid_i = 1'b0;
        rst_ni       = 1'b0;
        mq.delete();
        m_last  = 1'b1;
        m_pend  = 1'b0;
        m_proto = 1'b0;
        clear_logs();
        @(negedge clk_i);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (mq.size() > 0 && guard < 50) begin
            cycle(2'b00, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        check_val("drain_empty", 64'(outstanding_o), 64'd0);
    endtask

    initial begin
        logic [1:0] rreq;
        int         g0;
        int         g1;
        rst_ni       = 1'b1;
        h_req_i      = '0;
        h_we_i       = '0;
        h_is_cap_i   = '0;
        h_be_i       = '0;
        h_addr_i     = '0;
        h_wdata_i    = '0;
        dev_gnt_i    = 1'b0;
        dev_rvalid_i = 1'b0;
        dev_err_i    = 1'b0;
        dev_rdata_i  = '0;
        for (int h = 0; h < 2; h++) begin
            hwe[h]  = 1'b0;
            hcap[h] = 1'b0;
            refresh_host(h);
        end
        @(negedge clk_i);

        // Host 0 alone: 8 back-to-back reads with immediate responses.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(2'b01, 1'b1, mq.size() > 0, 1'b0);
        check_val("t1_grants", 64'(dut_gcnt[0]), 64'd8);
        drain();
        check_val("t1_rvalids", 64'(dut_rcnt[0]), 64'd8);
        check_val("t1_h1_idle", 64'(dut_gcnt[1] + dut_rcnt[1]), 64'd0);

        // Both hosts requesting continuously: strict alternation from host 0.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(2'b11, 1'b1, mq.size() > 0, 1'b0);
        check_val("t2_count", 64'(dut_glog.size()), 64'd10);
        for (int i = 0; i < dut_glog.size() && i < 10; i++)
            check_val("t2_order", 64'(dut_glog[i]), 64'(i % 2));
        drain();

        // Grant withheld: host 0 keeps the port while host 1 joins.
        do_reset();
        cycle(2'b01, 1'b0, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0, 1'b0);
        cycle(2'b11, 1'b1, 1'b0, 1'b0);
        cycle(2'b11, 1'b1, 1'b0, 1'b0);
        check_val("t3_count", 64'(dut_glog.size()), 64'd2);
        if (dut_glog.size() == 2) check_val("t3_order", 64'({dut_glog[0], dut_glog[1]}), 64'b01);
        drain();

        // FIFO full: forwarding stalls until a response frees a slot.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(2'b11, 1'b1, 1'b0, 1'b0);
        check_val("t4_occ", 64'(outstanding_o), 64'd4);
        check_val("t4_req_low", 64'(dev_req_o), 64'd0);
        cycle(2'b11, 1'b1, 1'b1, 1'b0);
        check_val("t4_oldest", 64'(dut_rlog.size() == 1 ? dut_rlog[0] : 1'b1), 64'd0);
        check_val("t4_no_gnt_on_pop", 64'(dut_glog.size()), 64'd4);
        cycle(2'b11, 1'b1, 1'b0, 1'b0);
        check_val("t4_regrant", 64'(dut_glog.size()), 64'd5);
        drain();

        // Host 0 write, host 1 read; error on the second response goes to host 1 only.
        do_reset();
        hwe[0] = 1'b1;
        hwe[1] = 1'b0;
        cycle(2'b11, 1'b1, 1'b0, 1'b0);
        cycle(2'b10, 1'b1, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, 1'b0);
        check_val("t5_err_first", 64'(dut_err_last), 64'b00);
        cycle(2'b00, 1'b0, 1'b1, 1'b1);
        check_val("t5_err_second", 64'(dut_err_last), 64'b10);
        check_val("t5_proto", 64'(proto_err_o), 64'd0);
        hwe[0] = 1'b0;

        // Spurious rvalid with nothing outstanding: sticky protocol error.
        do_reset();
        cycle(2'b00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(2'b00, 1'b0, 1'b0, 1'b0);
        check_val("t6_proto_sticky", 64'(proto_err_o), 64'd1);
        check_val("t6_no_rvalid", 64'(dut_rlog.size()), 64'd0);

        // Locked host withdrawing its request.
        do_reset();
        check_val("t7_proto_clear", 64'(proto_err_o), 64'd0);
        cycle(2'b01, 1'b0, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b0, 1'b0);
        cycle(2'b10, 1'b1, 1'b0, 1'b0);
        check_val("t7_proto_drop", 64'(proto_err_o), 64'd1);
        drain();

        // Randomized traffic; hosts hold req until granted.
        do_reset();
        rand_attr = 1'b1;
        rreq      = 2'b00;
        for (int i = 0; i < 400; i++) begin
            for (int h = 0; h < 2; h++)
                if (!rreq[h]) rreq[h] = 1'($urandom);
            g0 = dut_gcnt[0];
            g1 = dut_gcnt[1];
            cycle(rreq, 1'($urandom), (mq.size() > 0) && 1'($urandom), ($urandom_range(3) == 0));
            if (dut_gcnt[0] != g0) rreq[0] = 1'($urandom);
            if (dut_gcnt[1] != g1) rreq[1] = 1'($urandom);
        end
        for (int i = 0; i < 20 && m_pend; i++) cycle(rreq, 1'b1, 1'b0, 1'b0);
        drain();
        check_val("rand_proto", 64'(proto_err_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
